// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Responder side of the core's data-memory port. The core presents a word
// address, write data and a write strobe from its MEM stage. Read data comes
// back combinationally in the same cycle. Writes take effect on the rising
// edge that ends the cycle.
//
// Address map (full 32-bit decode, word granular):
//   0x000 .. DEPTH-1 : flop-based data RAM
//   0x100            : GPO register (read zero-extended, write low GPO_W bits)
//   0x101            : CYCLE counter (only when DMEM_CYCLE_COUNTER_EN is defined)
//   0x102            : GPI, two-flop synchronised (read only)
//   anything else    : reads 0, writes ignored
//
// Configuration macro:
//   DMEM_CYCLE_COUNTER_EN - adds the free-running cycle counter at 0x101.
//                           When undefined there are no counter flops and
//                           0x101 behaves as an unmapped address.
//
// Ports:
//   clk             rising-edge clock shared with the core
//   clr             asynchronous active-high reset
//   RAM_IN_ADDRESS  word address from the MEM stage
//   RAM_IN_DATA     write data
//   RAM_IN_WRITE    write strobe, 1 = write this cycle
//   RAM_OUT         read data for the address currently presented
//   gpo             general-purpose output register
//   gpi             asynchronous general-purpose input pins

module data_mem_responder #(
  parameter int DEPTH = 16,
  parameter int GPO_W = 8,
  parameter int GPI_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      RAM_IN_ADDRESS,
  input  logic [31:0]      RAM_IN_DATA,
  input  logic             RAM_IN_WRITE,
  output logic [31:0]      RAM_OUT,
  output logic [GPO_W-1:0] gpo,
  input  logic [GPI_W-1:0] gpi
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [31:0] ADDR_GPO   = 32'h0000_0100;
  localparam logic [31:0] ADDR_CYCLE = 32'h0000_0101;
  localparam logic [31:0] ADDR_GPI   = 32'h0000_0102;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [GPO_W-1:0] gpo_q;
  logic [GPO_W-1:0] gpo_d;
  logic [GPI_W-1:0] gpi_meta_q;
  logic [GPI_W-1:0] gpi_sync_q;
  logic [31:0]      rd_data;

  logic             hit_ram;
  logic [AW-1:0]    word_idx;

  // RAM hit requires every address bit above the index to be zero, so
  // aliases such as 0x010 or 0x8000_0003 stay unmapped.
  assign hit_ram  = (RAM_IN_ADDRESS < 32'(DEPTH));
  assign word_idx = RAM_IN_ADDRESS[AW-1:0];

  always_comb begin
    mem_d = mem_q;
    if (RAM_IN_WRITE && hit_ram) begin
      mem_d[word_idx] = RAM_IN_DATA;
    end
  end

  always_comb begin
    gpo_d = gpo_q;
    if (RAM_IN_WRITE && (RAM_IN_ADDRESS == ADDR_GPO)) begin
      gpo_d = RAM_IN_DATA[GPO_W-1:0];
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;

  // A write to the counter wins over the increment for that edge; wrap
  // from all-ones to zero falls out of the 32-bit add.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (RAM_IN_WRITE && (RAM_IN_ADDRESS == ADDR_CYCLE)) begin
      cycle_d = RAM_IN_DATA;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end
`endif

  // Read path is purely combinational from the registered state, so a
  // same-cycle write to the presented address still returns the old value.
  always_comb begin
    rd_data = '0;
    if (hit_ram) begin
      rd_data = mem_q[word_idx];
    end else if (RAM_IN_ADDRESS == ADDR_GPO) begin
      rd_data[GPO_W-1:0] = gpo_q;
`ifdef DMEM_CYCLE_COUNTER_EN
    end else if (RAM_IN_ADDRESS == ADDR_CYCLE) begin
      rd_data = cycle_q;
`endif
    end else if (RAM_IN_ADDRESS == ADDR_GPI) begin
      rd_data[GPI_W-1:0] = gpi_sync_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      gpo_q      <= '0;
      gpi_meta_q <= '0;
      gpi_sync_q <= '0;
    end else begin
      mem_q      <= mem_d;
      gpo_q      <= gpo_d;
      gpi_meta_q <= gpi;
      gpi_sync_q <= gpi_meta_q;
    end
  end

  assign RAM_OUT = rd_data;
  assign gpo     = gpo_q;

endmodule
